ic_program_loader: RTL
======================

// Module: ic_program_loader
// PURPOSE
// - Writer side of the instruction-cache write port (ic_write_*) and launch/retire controller for the compute unit.
// - Accepts a word stream from the host, writes each word to consecutive PCs, then pulses set_ready to start warps.
// - Monitors warp_active/warp_stopped until every warp has stopped, then reports done and accepts the next program.
// PARAMETERS
// - PcWidth      16    width of program counter / cache address
// - NumWarps     8     number of warps monitored
// - EncInstWidth 32    encoded instruction width
// - MemorySize   1024  instruction words in the cache; highest legal PC = MemorySize-1
// PORTS
// - clk_i            in   1             clock
// - rst_ni           in   1             asynchronous active-low reset
// - start_i          in   1             begin load; sampled only in IDLE
// - start_pc_i       in   PcWidth       PC of the first word; sampled with start_i
// - host_valid_i     in   1             host word valid
// - host_ready_o     out  1             loader ready for a host word
// - host_inst_i      in   EncInstWidth  instruction word
// - host_last_i      in   1             marks the final word of the program
// - ic_write_o       out  1             cache write strobe, registered
// - ic_write_pc_o    out  PcWidth       cache write address, registered
// - ic_write_inst_o  out  EncInstWidth  cache write data, registered
// - set_ready_o      out  1             one-cycle launch pulse to the fetcher
// - warp_active_i    in   NumWarps      from fetcher
// - warp_stopped_i   in   NumWarps      from fetcher
// - busy_o           out  1             state != IDLE
// - done_o           out  1             one-cycle pulse when all warps have stopped
// - error_o          out  1             sticky; write attempted at PC >= MemorySize
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0, including ic_write_pc_o and ic_write_inst_o. error_o cleared.
// - FSM states: IDLE, LOAD, LAUNCH, RUN.
//   - IDLE: host_ready_o=0. start_i=1 -> pc_q<=start_pc_i, error_o<=0, go to LOAD.
//   - LOAD: host_ready_o=1. On each handshake (valid&ready), in the next cycle:
//     ic_write_o=1, ic_write_pc_o=pc_q, ic_write_inst_o=host_inst_i; pc_q<=pc_q+1.
//     - Handshake with host_last_i=1 -> LAUNCH.
//     - Without a handshake, ic_write_o=0 in the next cycle.
//   - LAUNCH: lasts 1 cycle. The last write has landed by now. set_ready_o=1 for exactly this cycle -> RUN.
//   - RUN: host_ready_o=0. Wait one cycle for the fetcher to assert warp_active.
//     Then when (warp_stopped_i & warp_active_i) == warp_active_i -> done_o=1 for 1 cycle -> IDLE.
// - Throughput: 1 word/cycle; latency from handshake to ic_write_o is 1 cycle.
// - Overflow: a handshake with pc_q >= MemorySize is accepted and dropped (no ic_write_o), error_o<=1, and the FSM continues.
// - PC wrap: pc_q+1 wraps modulo 2^PcWidth. No saturation.
// - start_i outside IDLE is ignored. host_valid_i outside LOAD is ignored (not acknowledged).
// - Empty program: impossible. Every program has at least one word, and host_last_i on the first word is legal.
// - Reset mid-LOAD: writes already issued remain in the cache; the FSM returns to IDLE with no set_ready pulse.
// STRUCTURE
// - The shared package bgpu_pkg holds pc_t, enc_inst_t and the loader_state_e enum.
// - Host input passes through one stream_register (reuse the existing common cell, clr_i=0) to cut the host_ready_o path.
//   - Counted latency starts at the stream_register output handshake.
// - Single FSM plus PC counter; no other sub-modules.
// TESTING
// - start_pc=0x10, 3 words A,B,C (last on C) back-to-back -> ic_write at 0x10/0x11/0x12 on consecutive cycles; set_ready 1 cycle after C is written.
// - Host drops valid for 2 cycles between words -> ic_write_o low for exactly those cycles, PCs contiguous, no data loss.
// - start_pc=MemorySize-1, 2 words -> first written, second dropped, error_o=1 sticky until next start_i, set_ready still pulses.
// - RUN with warp_active=8'h0F: stopped goes 0x03 then 0x0F -> done_o pulses once, the cycle after 0x0F; busy_o falls with it.
// - start_i pulsed during LOAD and RUN -> ignored, PC unchanged; host_valid in RUN -> host_ready_o stays 0.
// - rst_ni asserted mid-LOAD after 2 writes -> all outputs 0 asynchronously, IDLE; a new start_i loads normally.

Source files
------------

// File: rtl/bgpu_pkg.sv
// Shared types for the compute-unit front end: PC / instruction words and
// the program loader state encoding.
package bgpu_pkg;

   localparam int unsigned DefPcWidth      = 16;
   localparam int unsigned DefEncInstWidth = 32;

   typedef logic [DefPcWidth-1:0]      pc_t;
   typedef logic [DefEncInstWidth-1:0] enc_inst_t;

   typedef enum logic [1:0] {
      LdIdle,
      LdLoad,
      LdLaunch,
      LdRun
   } loader_state_e;

endpackage

// File: rtl/stream_register.sv
// One-deep valid/ready register slice; accepts a new beat whenever it is
// empty or its current beat is being consumed.
module stream_register #(
   parameter type T = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic valid_i,
   output logic ready_o,
   input  T     data_i,
   output logic valid_o,
   input  logic ready_i,
   output T     data_o
);

   logic r_valid;
   T     r_data;

   assign ready_o = ready_i | ~r_valid;
   assign valid_o = r_valid;
   assign data_o  = r_data;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (clr_i) begin
         r_valid <= 1'b0;
      end else if (ready_o) begin
         r_valid <= valid_i;
         if (valid_i) r_data <= data_i;
      end
   end

endmodule

// File: rtl/ic_program_loader.sv
// Streams host words into the instruction cache at consecutive PCs, pulses
// set_ready to launch the warps, then waits for all active warps to stop.
module ic_program_loader
   import bgpu_pkg::*;
#(
   parameter int unsigned PcWidth      = 16,
   parameter int unsigned NumWarps     = 8,
   parameter int unsigned EncInstWidth = 32,
   parameter int unsigned MemorySize   = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [PcWidth-1:0]      start_pc_i,
   input  logic                    host_valid_i,
   output logic                    host_ready_o,
   input  logic [EncInstWidth-1:0] host_inst_i,
   input  logic                    host_last_i,
   output logic                    ic_write_o,
   output logic [PcWidth-1:0]      ic_write_pc_o,
   output logic [EncInstWidth-1:0] ic_write_inst_o,
   output logic                    set_ready_o,
   input  logic [NumWarps-1:0]     warp_active_i,
   input  logic [NumWarps-1:0]     warp_stopped_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    error_o
);

   loader_state_e r_state, w_state_nxt;

   logic [PcWidth-1:0]      r_pc, w_pc_nxt;
   logic                    r_drain, w_drain_nxt;
   logic                    r_run_first, w_run_first_nxt;
   logic                    r_last_in, w_last_in_nxt;
   logic                    r_error, w_error_nxt;
   logic                    r_done, w_done_nxt;
   logic                    r_wr, w_wr_nxt;
   logic [PcWidth-1:0]      r_wr_pc, w_wr_pc_nxt;
   logic [EncInstWidth-1:0] r_wr_inst, w_wr_inst_nxt;

   logic                    w_sr_in_valid, w_sr_in_ready;
   logic                    w_sr_valid, w_sr_ready;
   logic [EncInstWidth:0]   w_sr_data;
   logic                    w_in_range;
   logic                    w_all_stopped;

   // Host side stops taking words once the last one is in, so nothing from a
   // following program can be captured before the next start.
   assign w_sr_in_valid = host_valid_i & (r_state == LdLoad) & ~r_last_in;
   assign host_ready_o  = w_sr_in_ready & (r_state == LdLoad) & ~r_last_in;
   assign w_sr_ready    = (r_state == LdLoad) & ~r_drain;

   stream_register #(
      .T(logic [EncInstWidth:0])
   ) u_host_reg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (1'b0),
      .valid_i (w_sr_in_valid),
      .ready_o (w_sr_in_ready),
      .data_i  ({host_last_i, host_inst_i}),
      .valid_o (w_sr_valid),
      .ready_i (w_sr_ready),
      .data_o  (w_sr_data)
   );

   assign w_in_range    = 32'(r_pc) < MemorySize;
   assign w_all_stopped = (warp_stopped_i & warp_active_i) == warp_active_i;

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_drain_nxt     = r_drain;
      w_run_first_nxt = 1'b0;
      w_last_in_nxt   = r_last_in;
      w_error_nxt     = r_error;
      w_done_nxt      = 1'b0;
      w_wr_nxt        = 1'b0;
      w_wr_pc_nxt     = r_wr_pc;
      w_wr_inst_nxt   = r_wr_inst;
      unique case (r_state)
         LdIdle: begin
            if (start_i) begin
               w_pc_nxt      = start_pc_i;
               w_error_nxt   = 1'b0;
               w_last_in_nxt = 1'b0;
               w_drain_nxt   = 1'b0;
               w_state_nxt   = LdLoad;
            end
         end
         LdLoad: begin
            if (host_valid_i && host_ready_o && host_last_i) w_last_in_nxt = 1'b1;
            // One drain cycle lets the final write reach the cache before launch.
            if (r_drain) begin
               w_drain_nxt = 1'b0;
               w_state_nxt = LdLaunch;
            end else if (w_sr_valid) begin
               w_pc_nxt = r_pc + {{(PcWidth-1){1'b0}}, 1'b1};
               if (w_in_range) begin
                  w_wr_nxt      = 1'b1;
                  w_wr_pc_nxt   = r_pc;
                  w_wr_inst_nxt = w_sr_data[EncInstWidth-1:0];
               end else begin
                  w_error_nxt = 1'b1;
               end
               if (w_sr_data[EncInstWidth]) w_drain_nxt = 1'b1;
            end
         end
         LdLaunch: begin
            w_run_first_nxt = 1'b1;
            w_state_nxt     = LdRun;
         end
         LdRun: begin
            if (!r_run_first && w_all_stopped) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = LdIdle;
            end
         end
         default: w_state_nxt = LdIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= LdIdle;
         r_pc        <= '0;
         r_drain     <= 1'b0;
         r_run_first <= 1'b0;
         r_last_in   <= 1'b0;
         r_error     <= 1'b0;
         r_done      <= 1'b0;
         r_wr        <= 1'b0;
         r_wr_pc     <= '0;
         r_wr_inst   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_drain     <= w_drain_nxt;
         r_run_first <= w_run_first_nxt;
         r_last_in   <= w_last_in_nxt;
         r_error     <= w_error_nxt;
         r_done      <= w_done_nxt;
         r_wr        <= w_wr_nxt;
         r_wr_pc     <= w_wr_pc_nxt;
         r_wr_inst   <= w_wr_inst_nxt;
      end
   end

   assign ic_write_o      = r_wr;
   assign ic_write_pc_o   = r_wr_pc;
   assign ic_write_inst_o = r_wr_inst;
   assign set_ready_o     = (r_state == LdLaunch);
   assign busy_o          = (r_state != LdIdle);
   assign done_o          = r_done;
   assign error_o         = r_error;

endmodule
